ps2_cmd_sequencer: RTL and testbench

PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

---
 rtl/ps2_seq_pkg.sv | 19 +
 rtl/ps2_strobe_edge.sv | 22 ++
 rtl/ps2_cmd_sequencer.sv | 137 +++++++++++++
 tb/tb_ps2_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_seq_pkg.sv
// Shared scan-code constants, buffer geometry and FSM state type
// for the PS/2 command-line sequencer.
package ps2_seq_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] ENTER_CODE = 8'h5A;
  localparam logic [7:0] BKSP_CODE  = 8'h66;

  localparam int SLOTS = 4;

  typedef enum logic [1:0] {
    COLLECT,
    BREAK,
    EXTEND,
    PRESENT
  } state_t;

endpackage

// File: rtl/ps2_strobe_edge.sv
// Rising-edge detector on the PS/2 byte strobe; the byte is taken
// from ps2_info on the same edge that sees the strobe rise.
module ps2_strobe_edge (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_enable,
  input  logic [7:0] ps2_info,
  output logic       take,
  output logic [7:0] data
);

  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= ps2_enable;
  end

  assign take = ps2_enable & ~prev;
  assign data = ps2_info;

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Collects PS/2 make codes into a 4-slot line, committed on enter.
// Optional idle timeout: define PS2_SEQ_TIMEOUT_EN.
module ps2_cmd_sequencer
  import ps2_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ps2_info,
  input  logic        ps2_enable,
  input  logic        cmd_ready,
  output logic [31:0] cmd_word,
  output logic [2:0]  cmd_len,
  output logic        cmd_valid,
  output logic        overflow
);

  logic       take;
  logic [7:0] data;
  logic       tmo;

  state_t                state;
  logic [SLOTS-1:0][7:0] slots;
  logic [2:0]            count;
  logic                  valid_q;
  logic                  ovf_q;

  ps2_strobe_edge u_edge (
    .clock      (clock),
    .reset      (reset),
    .ps2_enable (ps2_enable),
    .ps2_info   (ps2_info),
    .take       (take),
    .data       (data)
  );

`ifdef PS2_SEQ_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IW-1:0] idle;
  logic          armed;

  // Only a partial line or a pending prefix can time out.
  assign armed = (state != PRESENT) &&
                 ((count != 3'd0) || (state != COLLECT));
  assign tmo   = armed && !take &&
                 (idle == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      idle <= '0;
    else if (take || !armed || tmo)
      idle <= '0;
    else
      idle <= idle + IW'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= COLLECT;
      slots   <= '0;
      count   <= 3'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (tmo) begin
      state <= COLLECT;
      slots <= '0;
      count <= 3'd0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (take) begin
            unique case (1'b1)
              data == BREAK_CODE: state <= BREAK;
              data == EXT_CODE:   state <= EXTEND;
              data == BKSP_CODE: begin
                if (count != 3'd0) begin
                  slots[count[1:0] - 2'd1] <= 8'h00;
                  count <= count - 3'd1;
                end
              end
              data == ENTER_CODE: begin
                if (count != 3'd0) begin
                  state   <= PRESENT;
                  valid_q <= 1'b1;
                end
              end
              default: begin
                if (count < 3'(SLOTS)) begin
                  slots[count[1:0]] <= data;
                  count <= count + 3'd1;
                end else begin
                  ovf_q <= 1'b1;
                end
              end
            endcase
          end
        end
        BREAK: begin
          if (take) state <= COLLECT;
        end
        EXTEND: begin
          if (take) begin
            if (data == BREAK_CODE) state <= BREAK;
            else                    state <= COLLECT;
          end
        end
        PRESENT: begin
          // Handshake wins over a byte arriving on the same edge.
          if (cmd_ready) begin
            state   <= COLLECT;
            slots   <= '0;
            count   <= 3'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
          end else if (take) begin
            ovf_q <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign cmd_word  = slots;
  assign cmd_len   = count;
  assign cmd_valid = valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed scoreboard bench for ps2_cmd_sequencer.
// Timeout steps run only with PS2_SEQ_TIMEOUT_EN defined.
module tb_ps2_cmd_sequencer;

  logic        clock;
  logic        reset;
  logic [7:0]  ps2_info;
  logic        ps2_enable;
  logic        cmd_ready;
  logic [31:0] cmd_word;
  logic [2:0]  cmd_len;
  logic        cmd_valid;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  len;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  ps2_cmd_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_info   (ps2_info),
    .ps2_enable (ps2_enable),
    .cmd_ready  (cmd_ready),
    .cmd_word   (cmd_word),
    .cmd_len    (cmd_len),
    .cmd_valid  (cmd_valid),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    ps2_info   = b;
    ps2_enable = 1'b1;
    @(negedge clock);
    ps2_enable = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input logic [2:0] l,
                      input logic o);
    exp_t e;
    e.word = w;
    e.len  = l;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic expect_line(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " valid"}, 32'(cmd_valid), 32'd1);
    e = sb.pop_front();
    chk({tag, " word"}, cmd_word, e.word);
    chk({tag, " len"}, 32'(cmd_len), 32'(e.len));
    chk({tag, " ovf"}, 32'(overflow), 32'(e.ovf));
    repeat (3) @(negedge clock);
    chk({tag, " hold word"}, cmd_word, e.word);
    chk({tag, " hold valid"}, 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    chk({tag, " done valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, " done len"}, 32'(cmd_len), 32'd0);
    chk({tag, " done word"}, cmd_word, 32'd0);
    chk({tag, " done ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    ps2_info   = 8'h00;
    ps2_enable = 1'b0;
    cmd_ready  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst word", cmd_word, 32'd0);
    chk("rst len", 32'(cmd_len), 32'd0);
    chk("rst valid", 32'(cmd_valid), 32'd0);
    chk("rst ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // two-key line, valid right after the enter edge
    push(32'h0000321C, 3'd2, 1'b0);
    send(8'h1C);
    send(8'h32);
    send(8'h5A);
    chk("basic latency", 32'(cmd_valid), 32'd1);
    expect_line("basic");

    // break code filtered
    push(32'h0000001C, 3'd1, 1'b0);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    send(8'h5A);
    expect_line("break");

    // extended prefix then break
    push(32'h00000015, 3'd1, 1'b0);
    send(8'h15);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'h5A);
    expect_line("ext");

    // fifth key overflows
    push(32'h2D241D15, 3'd4, 1'b1);
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    send(8'h2C);
    chk("ovf pre", 32'(overflow), 32'd1);
    send(8'h5A);
    expect_line("full");

    // backspace to empty, enter ignored
    send(8'h1C);
    send(8'h66);
    send(8'h66);
    send(8'h5A);
    repeat (2) @(negedge clock);
    chk("bksp valid", 32'(cmd_valid), 32'd0);
    chk("bksp len", 32'(cmd_len), 32'd0);
    push(32'h00000023, 3'd1, 1'b0);
    send(8'h23);
    send(8'h5A);
    expect_line("bksp");

    // held strobe with changing data gives one byte
    @(negedge clock);
    ps2_info   = 8'h21;
    ps2_enable = 1'b1;
    @(negedge clock);
    ps2_info = 8'h22;
    @(negedge clock);
    ps2_info = 8'h23;
    @(negedge clock);
    ps2_enable = 1'b0;
    chk("held len", 32'(cmd_len), 32'd1);
    chk("held word", cmd_word, 32'h00000021);

    // cmd_ready without a line is ignored
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    chk("idle ready len", 32'(cmd_len), 32'd1);
    push(32'h00000021, 3'd1, 1'b0);
    send(8'h5A);
    expect_line("held");

    // byte while presenting sets overflow, line unchanged
    send(8'h1C);
    send(8'h5A);
    send(8'h33);
    chk("present ovf", 32'(overflow), 32'd1);
    chk("present word", cmd_word, 32'h0000001C);
    chk("present len", 32'(cmd_len), 32'd1);
    push(32'h0000001C, 3'd1, 1'b1);
    expect_line("present");

    // handshake and byte on the same edge
    send(8'h1C);
    send(8'h5A);
    @(negedge clock);
    cmd_ready  = 1'b1;
    ps2_info   = 8'h33;
    ps2_enable = 1'b1;
    @(negedge clock);
    cmd_ready  = 1'b0;
    ps2_enable = 1'b0;
    chk("prio ovf", 32'(overflow), 32'd0);
    chk("prio valid", 32'(cmd_valid), 32'd0);
    chk("prio len", 32'(cmd_len), 32'd0);

    // asynchronous reset during a presented line
    send(8'h1C);
    send(8'h5A);
    chk("arst pre", 32'(cmd_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst valid", 32'(cmd_valid), 32'd0);
    chk("arst word", cmd_word, 32'd0);
    chk("arst len", 32'(cmd_len), 32'd0);

    // strobe already high at release is taken
    ps2_info   = 8'h44;
    ps2_enable = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ps2_enable = 1'b0;
    chk("rel len", 32'(cmd_len), 32'd1);
    chk("rel word", cmd_word, 32'h00000044);
    send(8'h66);
    chk("rel clr", 32'(cmd_len), 32'd0);

`ifdef PS2_SEQ_TIMEOUT_EN
    send(8'h1C);
    repeat (7) @(negedge clock);
    chk("tmo before", 32'(cmd_len), 32'd1);
    @(negedge clock);
    chk("tmo after", 32'(cmd_len), 32'd0);
    chk("tmo word", cmd_word, 32'd0);
`else
    send(8'h1C);
    repeat (20) @(negedge clock);
    chk("no tmo len", 32'(cmd_len), 32'd1);
    send(8'h66);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
